// File: rtl/par_serial_tx.sv
// Parallel-to-serial transmitter: loads a DLY_WIDTH-bit word and shifts it
// out MSB first, one bit per clock, with an optional idle gap after each
// frame. With no gap, a new word can be accepted in the last bit cycle so
// that frames run back to back.
module par_serial_tx #(
  parameter int DLY_WIDTH  = 8,
  parameter int GAP_CYCLES = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DLY_WIDTH-1:0] par_in,
  input  logic                 load_valid,
  output logic                 load_ready,
  output logic                 ser_out,
  output logic                 ser_valid,
  output logic                 busy,
  output logic                 done
);

  localparam int CNT_W = $clog2(DLY_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DLY_WIDTH - 1);
  localparam logic [3:0] LAST_GAP = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;
  localparam bit NO_GAP = (GAP_CYCLES == 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [DLY_WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [3:0]           gap_cnt_q, gap_cnt_d;
  logic                 last_bit;
  logic                 accept;

  // Output decode: everything is a function of the registered state only.
  always_comb begin
    last_bit   = (state_q == SHIFT) && (bit_cnt_q == LAST_BIT);
    load_ready = (state_q == IDLE) || (NO_GAP && last_bit);
    accept     = load_valid && load_ready;
    ser_valid  = (state_q == SHIFT);
    ser_out    = (state_q == SHIFT) ? shift_q[DLY_WIDTH-1] : 1'b0;
    busy       = (state_q != IDLE);
    done       = last_bit;
  end

  // Next-state logic: shifting, bit counting, gap timing and reload.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          shift_d   = par_in;
          bit_cnt_d = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        shift_d   = {shift_q[DLY_WIDTH-2:0], 1'b0};
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (last_bit) begin
          bit_cnt_d = '0;
          if (!NO_GAP) begin
            gap_cnt_d = '0;
            state_d   = GAP;
          end else if (accept) begin
            // Reload in the last bit cycle: the next frame follows with no idle bit.
            shift_d = par_in;
            state_d = SHIFT;
          end else begin
            state_d = IDLE;
          end
        end
      end
      GAP: begin
        gap_cnt_d = gap_cnt_q + 4'd1;
        if (gap_cnt_q == LAST_GAP) begin
          gap_cnt_d = '0;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset wins over any accept or frame progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

endmodule

// File: tb/tb_par_serial_tx.sv
// Bench for par_serial_tx: two instances (no gap and a 2-cycle gap) driven by
// directed and random stimulus, checked against a frame-level reference model
// through a scoreboard of expected serial bits.
module tb_par_serial_tx;

  localparam int W  = 8;
  localparam int G0 = 0;
  localparam int G1 = 2;

  typedef struct packed {
    logic         b;
    logic         d;
    logic [W-1:0] w;
  } ent_t;

  logic         clk = 1'b0;
  logic         rst [2];
  logic         lv  [2];
  logic [W-1:0] par [2];
  logic         lr  [2];
  logic         so  [2];
  logic         sv  [2];
  logic         bz  [2];
  logic         dn  [2];
  logic [W-1:0] rx  [2];

  int   checks = 0;
  int   errors = 0;

  // Reference model state: remaining busy cycles (frame + gap) of each instance.
  int   rem [2];
  int   head [2];
  int   tail [2];
  int   accepts [2];
  int   discarded [2];
  int   dones [2];
  bit   live [2];
  bit   acc_seen [2];
  bit   pend [2];
  logic [W-1:0] pend_w [2];
  ent_t fifo [2][64];
  ent_t mon_e;

  always #5 clk = ~clk;

  par_serial_tx #(.DLY_WIDTH(W), .GAP_CYCLES(G0)) dut0 (
    .clk(clk), .reset(rst[0]), .par_in(par[0]), .load_valid(lv[0]),
    .load_ready(lr[0]), .ser_out(so[0]), .ser_valid(sv[0]), .busy(bz[0]), .done(dn[0])
  );

  par_serial_tx #(.DLY_WIDTH(W), .GAP_CYCLES(G1)) dut1 (
    .clk(clk), .reset(rst[1]), .par_in(par[1]), .load_valid(lv[1]),
    .load_ready(lr[1]), .ser_out(so[1]), .ser_valid(sv[1]), .busy(bz[1]), .done(dn[1])
  );

  function automatic int gap_of(input int k);
    return (k == 0) ? G0 : G1;
  endfunction

  // Ready when nothing is in flight, or in the very last frame cycle when there is no gap.
  function automatic bit model_ready(input int k);
    return (rem[k] == 0) || (gap_of(k) == 0 && rem[k] == 1);
  endfunction

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst=%0d actual=%0h required=%0h t=%0t", name, k, act, exp, $time);
    end
  endtask

  // LSB-in loopback receivers.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++)
      if (sv[k] === 1'b1) rx[k] <= {rx[k][W-2:0], so[k]};
  end

  // Reference model: on each accept, queue the frame's bits MSB first.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      acc_seen[k] = 1'b0;
      if (rst[k]) begin
        if (rem[k] > gap_of(k) + 1) discarded[k]++;
        rem[k]  = 0;
        head[k] = 0;
        tail[k] = 0;
        live[k] = 1'b1;
      end else if (lv[k] && model_ready(k)) begin
        rem[k] = W + gap_of(k);
        for (int i = 0; i < W; i++) begin
          fifo[k][tail[k] % 64] = '{b: par[k][W-1-i], d: (i == W-1), w: par[k]};
          tail[k]++;
        end
        acc_seen[k] = 1'b1;
        accepts[k]++;
      end else if (rem[k] > 0) begin
        rem[k]--;
      end
    end
  end

  // Monitor: compare control outputs every cycle, pop a bit whenever ser_valid is high.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (live[k]) begin
        if (pend[k]) begin
          chk("loopback", k, 32'(rx[k]), 32'(pend_w[k]));
          pend[k] = 1'b0;
        end
        chk("load_ready", k, 32'(lr[k]), 32'(model_ready(k)));
        chk("busy", k, 32'(bz[k]), 32'(rem[k] > 0));
        chk("ser_valid", k, 32'(sv[k]), 32'(rem[k] > gap_of(k)));
        if (dn[k] === 1'b1) dones[k]++;
        if (sv[k] === 1'b1) begin
          if (head[k] == tail[k]) begin
            checks++;
            errors++;
            $display("FAIL unexpected_bit inst=%0d actual=ser_valid required=no_frame t=%0t", k, $time);
          end else begin
            mon_e = fifo[k][head[k] % 64];
            head[k]++;
            chk("ser_out", k, 32'(so[k]), 32'(mon_e.b));
            chk("done", k, 32'(dn[k]), 32'(mon_e.d));
            if (mon_e.d) begin
              pend[k]   = 1'b1;
              pend_w[k] = mon_e.w;
            end
          end
        end else begin
          chk("idle_ser_out", k, 32'(so[k]), 32'd0);
          chk("idle_done", k, 32'(dn[k]), 32'd0);
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Holds load_valid high and presents w0 then w1, advancing on each model accept.
  task automatic send_seq(input int k, input logic [W-1:0] w0, input logic [W-1:0] w1, input int n);
    int idx = 0;
    int cyc = 0;
    lv[k]  = 1'b1;
    par[k] = w0;
    while (idx < n && cyc < 200) begin
      step();
      cyc++;
      if (acc_seen[k]) begin
        idx++;
        par[k] = (idx == 1) ? w1 : W'($urandom);
        if (idx == n) lv[k] = 1'b0;
      end
    end
    lv[k] = 1'b0;
    checks++;
    if (idx != n) begin
      errors++;
      $display("FAIL send_timeout inst=%0d actual=%0d required=%0d", k, idx, n);
    end
  endtask

  task automatic wait_idle(input int k);
    int c = 0;
    while (rem[k] != 0 && c < 100) begin
      step();
      c++;
    end
    checks++;
    if (rem[k] != 0) begin
      errors++;
      $display("FAIL idle_timeout inst=%0d actual=%0d required=0", k, rem[k]);
    end
    step();
    step();
  endtask

  // Accepts 0xF0, then asserts reset with load_valid high during the 3rd bit cycle.
  task automatic reset_mid(input int k);
    send_seq(k, 8'hF0, 8'h00, 1);
    par[k] = W'($urandom);
    step();
    step();
    rst[k] = 1'b1;
    lv[k]  = 1'b1;
    par[k] = 8'h55;
    step();
    rst[k] = 1'b0;
    lv[k]  = 1'b0;
    step();
    step();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1;
      lv[k]  = 1'b0;
      par[k] = '0;
      rx[k]  = '0;
    end
    step();
    step();
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    step();

    // No-gap instance: single frames, loopback, back-to-back, reset mid-frame.
    send_seq(0, 8'hA5, 8'h00, 1);
    wait_idle(0);
    send_seq(0, 8'h3C, 8'h00, 1);
    wait_idle(0);
    send_seq(0, 8'hFF, 8'h00, 2);
    wait_idle(0);
    reset_mid(0);
    wait_idle(0);

    // Gap instance: load_valid held across the gap, then a mid-frame reset.
    send_seq(1, 8'h81, 8'h5A, 2);
    wait_idle(1);
    reset_mid(1);
    wait_idle(1);

    // Random load_valid, par_in churning every cycle, occasional reset.
    for (int i = 0; i < 1500; i++) begin
      step();
      for (int k = 0; k < 2; k++) begin
        rst[k] = ($urandom_range(0, 99) == 0);
        lv[k]  = $urandom_range(0, 1) == 1;
        par[k] = W'($urandom);
      end
    end
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b0;
      lv[k]  = 1'b0;
    end
    wait_idle(0);
    wait_idle(1);

    for (int k = 0; k < 2; k++) begin
      chk("pending_bits", k, 32'(tail[k] - head[k]), 32'd0);
      chk("frames_done", k, 32'(dones[k]), 32'(accepts[k] - discarded[k]));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
